// File: rtl/debounce_pkg.sv
// Shared constants, event bundle and counter sizing
// for the debounce_bank switch conditioner.
package debounce_pkg;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;
  localparam int HOLD_1S_25MHZ       = 25000000;

  typedef struct packed {
    logic press;
    logic rel;
    logic hold;
  } ch_evt_t;

  function automatic int cnt_width(input int limit);
    if (limit < 1) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchronizer, stability counter,
// hold counter and registered press/release/hold pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int   HOLD_LIMIT     = HOLD_1S_25MHZ,
  parameter int   SYNC_STAGES    = 2,
  parameter logic ACTIVE_LEVEL   = 1'b1,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    sw_i,
  output logic    level_o,
  output ch_evt_t evt_o,
  output ch_evt_t evt_d_o
);

  localparam int DW = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;
  logic                   level_q;
  logic                   level_d;
  logic [DW-1:0]          db_cnt_q;
  logic [DW-1:0]          db_cnt_d;
  logic                   accept;
  logic                   hold_d;
  ch_evt_t                evt_q;
  ch_evt_t                evt_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    accept   = 1'b0;
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        accept  = 1'b1;
        level_d = s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  if (HOLD_LIMIT > 0) begin : g_hold
    localparam int HW = cnt_width(HOLD_LIMIT);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_LIMIT);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_LIMIT - 1);

    logic [HW-1:0] h_cnt_q;
    logic [HW-1:0] h_cnt_d;
    logic          pressed;

    assign pressed = (level_q == ACTIVE_LEVEL);

    always_comb begin
      h_cnt_d = '0;
      if (pressed) begin
        if (h_cnt_q == H_MAX) h_cnt_d = H_MAX;
        else                  h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    // a release accepted on the reaching edge suppresses hold
    assign hold_d = pressed && !accept &&
                    (h_cnt_q == H_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) h_cnt_q <= '0;
      else         h_cnt_q <= h_cnt_d;
    end
  end else begin : g_no_hold
    assign hold_d = 1'b0;
  end

  always_comb begin
    evt_d       = '0;
    evt_d.press = accept && (s == ACTIVE_LEVEL);
    evt_d.rel   = accept && (s != ACTIVE_LEVEL);
    evt_d.hold  = hold_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      level_q  <= RESET_LEVEL;
      db_cnt_q <= '0;
      evt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign level_o = level_q;
  assign evt_o   = evt_q;
  assign evt_d_o = evt_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced switch channels with
// a registered any-event flag aligned to the pulses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   NUM_CH         = 4,
  parameter int   DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int   HOLD_LIMIT     = HOLD_1S_25MHZ,
  parameter int   SYNC_STAGES    = 2,
  parameter logic ACTIVE_LEVEL   = 1'b1,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Hold,
  output logic              o_Any_Event
);

  ch_evt_t [NUM_CH-1:0] evt;
  ch_evt_t [NUM_CH-1:0] evt_d;
  logic                 any_d;
  logic                 any_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .HOLD_LIMIT     (HOLD_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LEVEL   (ACTIVE_LEVEL),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk_i   (i_Clk),
      .rst_ni  (i_Rst_L),
      .sw_i    (i_Switch[n]),
      .level_o (o_Level[n]),
      .evt_o   (evt[n]),
      .evt_d_o (evt_d[n])
    );

    assign o_Press[n]   = evt[n].press;
    assign o_Release[n] = evt[n].rel;
    assign o_Hold[n]    = evt[n].hold;
  end

  // built from next-state events so it lands with the pulses
  always_comb begin
    any_d = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      any_d = any_d | (|evt_d[n]);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) any_q <= 1'b0;
    else          any_q <= any_d;
  end

  assign o_Any_Event = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: directed pin
// sequences queue expected events, a monitor checks them.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'b11;
  logic [1:0] lvl, prs, rel, hld;
  logic       any;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         at;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] h;
    logic [1:0] l;
  } ev_t;

  ev_t sb[$];
  ev_t me;

  debounce_bank #(
    .NUM_CH         (2),
    .DEBOUNCE_LIMIT (4),
    .HOLD_LIMIT     (10),
    .SYNC_STAGES    (2),
    .ACTIVE_LEVEL   (1'b1),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Switch    (sw),
    .o_Level     (lvl),
    .o_Press     (prs),
    .o_Release   (rel),
    .o_Hold      (hld),
    .o_Any_Event (any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int at, input logic [1:0] p,
                      input logic [1:0] r, input logic [1:0] h,
                      input logic [1:0] l);
    ev_t e;
    e.at = at; e.p = p; e.r = r; e.h = h; e.l = l;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_event cyc=%0d got=none want_at=%0d",
               cyc, sb[0].at);
      void'(sb.pop_front());
    end
    if (any || (|{prs, rel, hld})) begin
      tests++;
      if (any !== (|{prs, rel, hld})) begin
        fails++;
        $display("FAIL any_event cyc=%0d got=%b want=%b",
                 cyc, any, |{prs, rel, hld});
      end
      if (sb.size() == 0 || sb[0].at != cyc) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event cyc=%0d got p=%b r=%b h=%b",
                 cyc, prs, rel, hld);
      end else begin
        me = sb.pop_front();
        tests++;
        if ({prs, rel, hld, lvl} !== {me.p, me.r, me.h, me.l}) begin
          fails++;
          $display("FAIL event cyc=%0d got p=%b r=%b h=%b l=%b want p=%b r=%b h=%b l=%b",
                   cyc, prs, rel, hld, lvl,
                   me.p, me.r, me.h, me.l);
        end
      end
    end
  end

  initial begin
    int r, a, g, p, b, e, h, u, s0, s1, q0, r2, z;

    at(2);
    chk("reset_outputs", {lvl, prs, rel, hld, any}, 0);
    at(4);
    rst_n = 1'b1;
    r = cyc;
    push(r + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    push(r + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    at(r + 5);
    chk("level_before_latency", lvl, 0);
    at(r + 22);
    chk("hold_no_repeat_level", lvl, 2'b11);
    sw = 2'b00;
    a = cyc;
    push(a + 6, 2'b00, 2'b11, 2'b00, 2'b00);
    at(a + 12);

    sw[0] = 1'b1;
    g = cyc;
    at(g + 3);
    sw[0] = 1'b0;
    at(g + 12);
    chk("glitch3_level", lvl, 0);

    sw[0] = 1'b1;
    p = cyc;
    push(p + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    push(p + 10, 2'b00, 2'b01, 2'b00, 2'b00);
    at(p + 4);
    sw[0] = 1'b0;
    at(p + 14);
    chk("pulse4_level_after", lvl, 0);

    b = cyc;
    sw[0] = 1'b1;
    push(b + 14, 2'b01, 2'b00, 2'b00, 2'b01);
    push(b + 24, 2'b00, 2'b00, 2'b01, 2'b01);
    at(b + 2); sw[0] = 1'b0;
    at(b + 4); sw[0] = 1'b1;
    at(b + 6); sw[0] = 1'b0;
    at(b + 8); sw[0] = 1'b1;
    at(b + 13);
    chk("bounce_not_yet", lvl, 0);
    at(b + 26);
    chk("bounce_level", lvl, 2'b01);
    sw[0] = 1'b0;
    e = cyc;
    push(e + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    at(e + 10);

    sw[1] = 1'b1;
    h = cyc;
    push(h + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    push(h + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    at(h + 30);
    chk("hold_held_level", lvl, 2'b10);
    sw[1] = 1'b0;
    u = cyc;
    push(u + 6, 2'b00, 2'b10, 2'b00, 2'b00);
    at(u + 10);

    sw[1] = 1'b1;
    s0 = cyc;
    push(s0 + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    push(s0 + 15, 2'b00, 2'b10, 2'b00, 2'b00);
    at(s0 + 9);
    sw[1] = 1'b0;
    at(s0 + 20);
    sw[1] = 1'b1;
    s1 = cyc;
    push(s1 + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    push(s1 + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    at(s1 + 20);
    sw[1] = 1'b0;
    push(s1 + 26, 2'b00, 2'b10, 2'b00, 2'b00);
    at(s1 + 32);

    sw[1] = 1'b1;
    q0 = cyc;
    push(q0 + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    at(q0 + 8);
    sw[0] = 1'b1;
    at(q0 + 13);
    chk("pre_reset_level", lvl, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {lvl, prs, rel, hld, any}, 0);
    at(q0 + 15);
    rst_n = 1'b1;
    r2 = cyc;
    push(r2 + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    push(r2 + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    at(r2 + 5);
    chk("restart_level_low", lvl, 0);
    at(r2 + 20);
    sw = 2'b00;
    z = cyc;
    push(z + 6, 2'b00, 2'b11, 2'b00, 2'b00);
    at(z + 12);
    chk("queue_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Multi-channel switch/button conditioner for board inputs such as buttons and DIP switches. Each channel has:
- an input synchronizer
- a stability-counter debouncer
- one-cycle press/release event pulses
- optional long-press (hold) detection

It sits between the raw FPGA pins and the user logic (7-segment counters, menu FSMs), so downstream logic never needs its own edge detectors.

Parameters:
NUM_CH, 4, number of independent channels
DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a new level (10 ms at 25 MHz); must be >= 1
HOLD_LIMIT, 25000000, cycles a channel must stay pressed before o_Hold fires (1 s at 25 MHz); 0 disables hold detection
SYNC_STAGES, 2, synchronizer flop depth; must be >= 2
ACTIVE_LEVEL, 1'b1, debounced level that counts as "pressed"
RESET_LEVEL, 1'b0, value loaded into synchronizers and debounced state at reset

Ports:
i_Clk  input  1  system clock; the only clock
i_Rst_L  input  1  asynchronous active-low reset
i_Switch  input  NUM_CH  raw asynchronous switch inputs, bit n = channel n
o_Level  output  NUM_CH  debounced level per channel
o_Press  output  NUM_CH  1-cycle pulse when o_Level[n] becomes ACTIVE_LEVEL
o_Release  output  NUM_CH  1-cycle pulse when o_Level[n] leaves ACTIVE_LEVEL
o_Hold  output  NUM_CH  1-cycle pulse when channel n has been pressed for HOLD_LIMIT cycles
o_Any_Event  output  1  OR of all o_Press, o_Release and o_Hold bits, same cycle

Behaviour:
- Clock and reset:
  - Single clock i_Clk.
  - Reset is asynchronous, active-low (i_Rst_L). Assertion takes effect immediately regardless of clock.
  - Deassertion is assumed synchronous to i_Clk at board level.
- Reset values:
  - Synchronizer flops = RESET_LEVEL.
  - o_Level = {NUM_CH{RESET_LEVEL}}.
  - All counters = 0.
  - o_Press, o_Release, o_Hold, o_Any_Event = 0.
  - Reset mid-count discards all partial counts. No event pulses are generated by reset entry or exit.
- Synchronizer: i_Switch[n] passes through SYNC_STAGES flops; s[n] is the last stage.
- Debounce counter (per channel, width $clog2(DEBOUNCE_LIMIT+1)):
  - If s[n] == o_Level[n]: count <= 0.
  - Else if count == DEBOUNCE_LIMIT-1: o_Level[n] <= s[n]; count <= 0.
  - Else: count <= count+1.
- Acceptance and latency:
  - A new level is accepted after exactly DEBOUNCE_LIMIT consecutive cycles of s[n] != o_Level[n].
  - Pin-to-o_Level latency = SYNC_STAGES + DEBOUNCE_LIMIT cycles.
  - A glitch shorter than DEBOUNCE_LIMIT cycles leaves o_Level unchanged and zeroes the counter.
- Event pulses:
  - o_Press[n] / o_Release[n] are registered and asserted in the same cycle o_Level[n] first shows its new value, for exactly 1 cycle.
  - Press and release can never be asserted together on one channel.
- Hold counter (per channel, width $clog2(HOLD_LIMIT+1); absent when HOLD_LIMIT=0, in which case o_Hold tied 0):
  - While o_Level[n] == ACTIVE_LEVEL, increment, saturating at HOLD_LIMIT.
  - o_Hold[n] pulses 1 cycle on the transition to HOLD_LIMIT. It fires at most once per press, i.e. HOLD_LIMIT cycles after the o_Press pulse.
  - Any cycle with o_Level[n] != ACTIVE_LEVEL clears the hold counter.
  - A release in the same cycle the count would reach HOLD_LIMIT produces no o_Hold.
- Channel independence: simultaneous events on multiple channels are all reported in the same cycle. o_Any_Event is a registered OR of the event bits, aligned with them.
- ACTIVE_LEVEL=0 (active-low buttons): press = debounced 1->0 transition, and hold counts while low.

Decomposition:
- Shared package debounce_pkg:
  - counter-width helper function (clog2 of limit+1)
  - default timing constants DEBOUNCE_10MS_25MHZ=250000 and HOLD_1S_25MHZ=25000000
- Natural sub-module: debounce_channel, one instance per channel via a generate loop. It contains the synchronizer, debounce counter, hold counter and pulse generation for one bit.
- Top level debounce_bank contains only the generate loop and the o_Any_Event OR/register.

Test Plan (NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, SYNC_STAGES=2, ACTIVE_LEVEL=1, RESET_LEVEL=0):
- Reset: hold i_Rst_L=0 with i_Switch=2'b11 -> all outputs 0 during reset. After release, o_Level[1:0] rises at cycle 2+4=6, with o_Press=2'b11 for 1 cycle and o_Any_Event=1 in that same cycle.
- Glitch rejection: ch0 at 0, pulse i_Switch[0]=1 for 3 cycles, then 0 -> o_Level[0] stays 0, no o_Press. A 4-cycle pulse -> o_Level[0]=1 six cycles after the first high sample.
- Bounce: toggle i_Switch[0] 1,0,1,0,1 at 2-cycle intervals, then hold at 1 -> exactly one o_Press, 6 cycles after the final stable 1.
- Hold: press ch1 and keep it high -> o_Press[1] at cycle T, o_Hold[1] at T+10, no further o_Hold while held. Release -> o_Release[1] 6 cycles after the pin falls.
- Short press: hold ch1 stable-high only long enough that release is accepted at T+9 -> no o_Hold. A second full press starts the hold count from 0.
- Async reset mid-operation: assert i_Rst_L=0 mid-count with ch0 counter=3 and ch1 hold count=7 (not aligned to a clock edge) -> outputs clear immediately. After deassertion no stale events appear, and full timing restarts.
